// File: rtl/win_sequencer.sv
// Win sequencer: latches a winner on score update, blinks the win text for a set
// number of frames, waits for start, then pulses score_clear and resumes play.
`ifndef PLAYER_1_COLOR
`define PLAYER_1_COLOR 3'b100
`endif
`ifndef PLAYER_2_COLOR
`define PLAYER_2_COLOR 3'b001
`endif

module win_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int HOLD_FRAMES  = 300,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       score_update,
  input  logic [3:0] score_1,
  input  logic [3:0] score_2,
  input  logic       start,
  output logic [2:0] winner,
  output logic       game_run,
  output logic       score_clear,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    SHOW    = 2'd1,
    WAIT    = 2'd2,
    RESTART = 2'd3
  } state_t;

  localparam logic [3:0]  WIN_THR    = 4'(WIN_SCORE);
  localparam logic [11:0] HOLD_LAST  = 12'(HOLD_FRAMES - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

  state_t      state, state_n;
  logic [2:0]  latched, latched_n;
  logic [11:0] frame_cnt, frame_cnt_n;
  logic [7:0]  blink_cnt, blink_cnt_n;
  logic        blink_on, blink_on_n;
  logic [2:0]  winner_n;
  logic        game_run_n, score_clear_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PLAY;
      latched     <= 3'd0;
      frame_cnt   <= 12'd0;
      blink_cnt   <= 8'd0;
      blink_on    <= 1'b1;
      winner      <= 3'd0;
      game_run    <= 1'b1;
      score_clear <= 1'b0;
    end else begin
      state       <= state_n;
      latched     <= latched_n;
      frame_cnt   <= frame_cnt_n;
      blink_cnt   <= blink_cnt_n;
      blink_on    <= blink_on_n;
      winner      <= winner_n;
      game_run    <= game_run_n;
      score_clear <= score_clear_n;
    end
  end

  assign state_o = state;

  // Next state and counters; outputs are derived from the next state so they
  // are registered together with it and change one clock after the trigger.
  always_comb begin
    state_n     = state;
    latched_n   = latched;
    frame_cnt_n = frame_cnt;
    blink_cnt_n = blink_cnt;
    blink_on_n  = blink_on;
    unique case (state)
      PLAY: begin
        if (score_update && (score_1 >= WIN_THR || score_2 >= WIN_THR)) begin
          latched_n   = (score_1 >= WIN_THR) ? `PLAYER_1_COLOR : `PLAYER_2_COLOR;
          state_n     = SHOW;
          frame_cnt_n = 12'd0;
          blink_cnt_n = 8'd0;
          blink_on_n  = 1'b1;
        end
      end
      SHOW: begin
        if (frame_tick) begin
          if (frame_cnt == HOLD_LAST) begin
            state_n = WAIT;
          end else begin
            frame_cnt_n = frame_cnt + 12'd1;
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt_n = 8'd0;
              blink_on_n  = ~blink_on;
            end else begin
              blink_cnt_n = blink_cnt + 8'd1;
            end
          end
        end
      end
      WAIT: begin
        if (start) state_n = RESTART;
      end
      RESTART: state_n = PLAY;
      default: state_n = PLAY;
    endcase
  end

  always_comb begin
    winner_n      = 3'd0;
    game_run_n    = 1'b0;
    score_clear_n = 1'b0;
    unique case (state_n)
      PLAY:    game_run_n    = 1'b1;
      SHOW:    winner_n      = blink_on_n ? latched_n : 3'd0;
      WAIT:    winner_n      = latched_n;
      RESTART: score_clear_n = 1'b1;
      default: game_run_n    = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_win_sequencer.sv
// Scoreboard bench for win_sequencer: a frame-count reference model predicts the
// outputs each cycle; a monitor compares them against the DUT on the falling edge.
`ifndef PLAYER_1_COLOR
`define PLAYER_1_COLOR 3'b100
`endif
`ifndef PLAYER_2_COLOR
`define PLAYER_2_COLOR 3'b001
`endif

module tb_win_sequencer;
  localparam int WIN   = 7;
  localparam int HOLD  = 10;
  localparam int BLINK = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0, score_update = 1'b0, start = 1'b0;
  logic [3:0] score_1 = 4'd0, score_2 = 4'd0;
  logic [2:0] winner;
  logic       game_run, score_clear;
  logic [1:0] state_o;

  win_sequencer #(.WIN_SCORE(WIN), .HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .score_update(score_update),
    .score_1(score_1), .score_2(score_2), .start(start),
    .winner(winner), .game_run(game_run), .score_clear(score_clear), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] w;
    logic       run;
    logic       clr;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phase name, winning code, and ticks seen since the win.
  int       m_st   = 0;
  logic [2:0] m_code = 3'd0;
  int       m_ticks = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    case (m_st)
      0: e.run = 1'b1;
      1: e.w = (((m_ticks / BLINK) % 2) == 0) ? m_code : 3'd0;
      2: e.w = m_code;
      default: e.clr = 1'b1;
    endcase
    e.st = 2'(m_st);
    return e;
  endfunction

  task automatic model_reset();
    m_st = 0; m_code = 3'd0; m_ticks = 0;
  endtask

  task automatic model_step(input logic r, input logic t, input logic u,
                            input int s1, input int s2, input logic go);
    if (r) begin
      model_reset();
      return;
    end
    case (m_st)
      0: if (u) begin
        if (s1 >= WIN)      begin m_code = `PLAYER_1_COLOR; m_st = 1; m_ticks = 0; end
        else if (s2 >= WIN) begin m_code = `PLAYER_2_COLOR; m_st = 1; m_ticks = 0; end
      end
      1: if (t) begin
        if (m_ticks == HOLD - 1) m_st = 2;
        else m_ticks++;
      end
      2: if (go) m_st = 3;
      default: m_st = 0;
    endcase
  endtask

  // One clock of stimulus; the expectation for the coming rising edge is queued.
  task automatic drive(input logic r, input logic t, input logic u,
                       input int s1, input int s2, input logic go);
    @(negedge clk);
    #1;
    reset = r; frame_tick = t; score_update = u; start = go;
    score_1 = 4'(s1); score_2 = 4'(s2);
    model_step(r, t, u, s1, s2, go);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk({name, "_state"},  int'(state_o),     0);
    chk({name, "_winner"}, int'(winner),      0);
    chk({name, "_run"},    int'(game_run),    1);
    chk({name, "_clear"},  int'(score_clear), 0);
  endtask

  // Monitor: every falling edge the DUT outputs are compared with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("winner",      int'(winner),      int'(e.w));
        chk("game_run",    int'(game_run),    int'(e.run));
        chk("score_clear", int'(score_clear), int'(e.clr));
        chk("state_o",     int'(state_o),     int'(e.st));
      end
    end
  end

  initial begin
    int budget;
    drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 9, 9, 1'b1);
    idle(2);
    // Non-win update, then a P1 win through the full blink/hold sequence.
    drive(1'b0, 1'b0, 1'b1, 6, 6, 1'b0);
    idle(1);
    drive(1'b0, 1'b0, 1'b1, 7, 3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 0, 9, 1'b0);
    for (int i = 0; i < HOLD; i++) begin
      drive(1'b0, 1'b1, 1'b0, 0, 0, (i == 4));
      idle(1);
    end
    drive(1'b0, 1'b1, 1'b1, 9, 9, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    idle(3);
    // Tie goes to P1, then a P2 win.
    drive(1'b0, 1'b0, 1'b1, 7, 7, 1'b0);
    for (int i = 0; i < HOLD; i++) drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 6, 7, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    // Asynchronous reset in the middle of SHOW.
    async_reset_check("async_show");
    drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(2);
    // Randomized play with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 9)),
            int'($urandom_range(0, 9)), ($urandom_range(0, 3) == 0));
    end
    idle(1);
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
